arc4_encrypt: RTL
=================

ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-003 SHALL have ports en (in, 1: start request) and rdy (out, 1: idle, accepts en).
REQ-004 SHALL have port key, input, 24: ARC4 key; key[23:16] is key byte 0, key[7:0] is key byte 2.
REQ-005 SHALL have ports pt_addr (out, 8) and pt_rddata (in, 8): plaintext memory read port with 1-cycle read latency.
REQ-006 SHALL have ports ct_addr (out, 8), ct_wrdata (out, 8) and ct_wren (out, 1): ciphertext memory write port.
REQ-007 SHALL have ports s_addr (out, 8), s_wrdata (out, 8), s_wren (out, 1) and s_rddata (in, 8): state-array memory port with 1-cycle read latency.

Function
REQ-008 SHALL treat each message as length-prefixed: byte 0 is length L (0..255), bytes 1..L are data.
REQ-009 SHALL start only when en=1 and rdy=1 in the same cycle; SHALL latch key that cycle and deassert rdy on the next cycle.
REQ-010 SHALL ignore en while rdy=0.
REQ-011 SHALL use states IDLE -> INIT -> KSA -> PRGA -> IDLE; rdy=1 only in IDLE.
REQ-012 INIT SHALL write s[i]=i for i=0..255, one write per cycle.
REQ-013 KSA SHALL, for i=0..255, compute j=(j+s[i]+key byte (i mod 3)) mod 256 and swap s[i] and s[j]; j starts at 0.
REQ-014 PRGA SHALL read L from pt[0], write ct[0]=L, then for k=1..L: i=i+1, j=j+s[i], swap, pad=s[(s[i]+s[j]) mod 256], ct[k]=pt[k] XOR pad; i and j both restart at 0.
REQ-015 SHALL perform all index arithmetic modulo 256 (8-bit wrap).
REQ-016 SHALL use exactly one s-memory access per cycle, and SHALL NOT read a location in the cycle after writing it without using the written value.
REQ-017 SHALL assert ct_wren for exactly one cycle per ciphertext byte; L+1 writes per message in total.
REQ-018 For L=0, SHALL write only ct[0]=0, then return to IDLE.
REQ-019 SHALL return to IDLE and raise rdy within 8 cycles of the last ct write.
REQ-020 SHALL be restartable back-to-back: en in the first rdy=1 cycle starts a new message.

Reset
REQ-021 Reset SHALL force IDLE with rdy=1, ct_wren=0, s_wren=0, all addresses=0, ct_wrdata=0, s_wrdata=0, and i, j and the latched key cleared.
REQ-022 Reset asserted mid-operation SHALL abort immediately; no further memory writes occur until a new start.

Configuration
REQ-023 With ARC4_ENCRYPT_PRINTABLE_CHK_EN defined, SHALL add output pt_printable (1 bit): cleared at start, valid when rdy rises, 1 iff every plaintext byte 1..L lies in 0x20..0x7E (1 for L=0).
REQ-024 Without ARC4_ENCRYPT_PRINTABLE_CHK_EN, pt_printable and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 SHALL place the state enum, key length constant (3) and printable bounds (0x20, 0x7E) in shared package arc4_pkg, used by the cracker blocks too.
REQ-026 SHALL implement the S-array swap sequencer (read i, read j, write i, write j) as sub-module arc4_swap, shared by KSA and PRGA.

Verification
REQ-027 Reset only -> rdy=1, ct_wren=0, s_wren=0.
REQ-028 key=0x4B6579 ("Key"), pt = 09 followed by "Plaintext" -> ct = 09 BB F3 16 E8 D9 40 AF 0A D3, then rdy=1.
REQ-029 pt[0]=00, any key -> exactly one write, ct[0]=00; rdy returns within 8 cycles.
REQ-030 Pulse en again while busy, then change key mid-run -> output identical to REQ-028.
REQ-031 Assert rst at KSA step 100, then restart with REQ-028 stimulus -> REQ-028 output; no writes while rst is high.
REQ-032 With ARC4_ENCRYPT_PRINTABLE_CHK_EN: "Plaintext" -> pt_printable=1; message 02 41 0A -> pt_printable=0.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 types and constants for the encrypt and cracker blocks.
package arc4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_PRGA
    } arc4_state_t;

    typedef enum logic [2:0] {
        PH_START,
        PH_WAIT,
        PH_LEN,
        PH_LENW,
        PH_PAD,
        PH_OUT
    } arc4_phase_t;

    typedef enum logic [2:0] {
        SW_IDLE,
        SW_RDI,
        SW_RDJ,
        SW_WRI,
        SW_WRJ
    } arc4_swap_t;

    localparam int KEY_LEN = 3;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/arc4_swap.sv
// S-array swap sequencer: read s[i], read s[j'], write s[i], write s[j'].
// j' = j + s[i] + add; old s[i]/s[j'] are kept for the PRGA pad lookup.
module arc4_swap
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] i,
    input  logic [7:0] j,
    input  logic [7:0] add,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       wren,
    output logic [7:0] j_out,
    output logic [7:0] si,
    output logic [7:0] sj
);

    arc4_swap_t step_q, step_d;
    logic [7:0] i_q, j_q, add_q, si_q, sj_q;
    logic [7:0] j_new;

    assign j_new = j_q + rd_data + add_q;
    assign busy  = (step_q != SW_IDLE);
    assign j_out = j_q;
    assign si    = si_q;
    assign sj    = sj_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= SW_IDLE;
            i_q    <= '0;
            j_q    <= '0;
            add_q  <= '0;
            si_q   <= '0;
            sj_q   <= '0;
        end else begin
            step_q <= step_d;
            if (step_q == SW_IDLE && start) begin
                i_q   <= i;
                j_q   <= j;
                add_q <= add;
            end
            if (step_q == SW_RDJ) begin
                si_q <= rd_data;
                j_q  <= j_new;
            end
            if (step_q == SW_WRI) begin
                sj_q <= rd_data;
            end
        end
    end

    always_comb begin
        step_d = step_q;
        addr   = '0;
        wrdata = '0;
        wren   = 1'b0;
        done   = 1'b0;
        unique case (step_q)
            SW_IDLE: begin
                if (start) step_d = SW_RDI;
            end
            SW_RDI: begin
                addr   = i_q;
                step_d = SW_RDJ;
            end
            SW_RDJ: begin
                addr   = j_new;
                step_d = SW_WRI;
            end
            SW_WRI: begin
                addr   = i_q;
                wren   = 1'b1;
                wrdata = rd_data;
                step_d = SW_WRJ;
            end
            SW_WRJ: begin
                addr   = j_q;
                wren   = 1'b1;
                wrdata = si_q;
                done   = 1'b1;
                step_d = SW_IDLE;
            end
            default: step_d = SW_IDLE;
        endcase
    end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryption of a length-prefixed message with a 24-bit key.
// Optional pt_printable output under ARC4_ENCRYPT_PRINTABLE_CHK_EN.
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    input  logic [7:0]  s_rddata
`ifdef ARC4_ENCRYPT_PRINTABLE_CHK_EN
    ,
    output logic        pt_printable
`endif
);

    localparam logic [1:0] KLAST = 2'(KEY_LEN - 1);

    arc4_state_t state_q, state_d;
    arc4_phase_t ph_q, ph_d;

    logic [23:0] key_q;
    logic [7:0]  i_q, j_q, cnt_q, len_q;
    logic [1:0]  kidx_q;
    logic [7:0]  kbyte;

    logic        sw_start, sw_busy, sw_done, sw_wren;
    logic [7:0]  sw_i, sw_add, sw_addr, sw_wrdata;
    logic [7:0]  sw_j, sw_si, sw_sj;

    logic [7:0]  top_addr, top_wrdata;
    logic        top_wren;

    logic        w_vld_q, byp_q;
    logic [7:0]  w_addr_q, w_data_q, byp_data_q;
    logic [7:0]  rd_data;

    always_comb begin
        unique case (kidx_q)
            2'd0:    kbyte = key_q[23:16];
            2'd1:    kbyte = key_q[15:8];
            default: kbyte = key_q[7:0];
        endcase
    end

    // A read of the location written the cycle before returns the written value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_vld_q    <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            w_vld_q    <= s_wren;
            w_addr_q   <= s_addr;
            w_data_q   <= s_wrdata;
            byp_q      <= !s_wren && w_vld_q
                          && (s_addr == w_addr_q);
            byp_data_q <= w_data_q;
        end
    end

    assign rd_data = byp_q ? byp_data_q : s_rddata;

    arc4_swap u_swap (
        .clk     (clk),
        .rst     (rst),
        .start   (sw_start),
        .i       (sw_i),
        .j       (j_q),
        .add     (sw_add),
        .rd_data (rd_data),
        .busy    (sw_busy),
        .done    (sw_done),
        .addr    (sw_addr),
        .wrdata  (sw_wrdata),
        .wren    (sw_wren),
        .j_out   (sw_j),
        .si      (sw_si),
        .sj      (sw_sj)
    );

    assign s_addr   = sw_busy ? sw_addr   : top_addr;
    assign s_wrdata = sw_busy ? sw_wrdata : top_wrdata;
    assign s_wren   = sw_busy ? sw_wren   : top_wren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ph_q    <= PH_START;
            key_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        key_q  <= key;
                        cnt_q  <= '0;
                        i_q    <= '0;
                        j_q    <= '0;
                        kidx_q <= '0;
                    end
                end
                ST_INIT: cnt_q <= cnt_q + 8'd1;
                ST_KSA: begin
                    if (ph_q == PH_WAIT && sw_done) begin
                        if (i_q == 8'hFF) begin
                            i_q <= '0;
                            j_q <= '0;
                        end else begin
                            i_q    <= i_q + 8'd1;
                            j_q    <= sw_j;
                            kidx_q <= (kidx_q == KLAST) ? 2'd0
                                                        : kidx_q + 2'd1;
                        end
                    end
                end
                ST_PRGA: begin
                    unique case (ph_q)
                        PH_LENW: begin
                            len_q <= pt_rddata;
                            cnt_q <= 8'd1;
                        end
                        PH_START: i_q <= i_q + 8'd1;
                        PH_WAIT:  if (sw_done) j_q <= sw_j;
                        PH_OUT:   cnt_q <= cnt_q + 8'd1;
                        default:  ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        rdy        = 1'b0;
        sw_start   = 1'b0;
        sw_i       = i_q;
        sw_add     = '0;
        top_addr   = '0;
        top_wrdata = '0;
        top_wren   = 1'b0;
        pt_addr    = '0;
        ct_addr    = '0;
        ct_wrdata  = '0;
        ct_wren    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) state_d = ST_INIT;
            end
            ST_INIT: begin
                top_addr   = cnt_q;
                top_wrdata = cnt_q;
                top_wren   = 1'b1;
                if (cnt_q == 8'hFF) begin
                    state_d = ST_KSA;
                    ph_d    = PH_START;
                end
            end
            ST_KSA: begin
                unique case (ph_q)
                    PH_START: begin
                        sw_start = 1'b1;
                        sw_add   = kbyte;
                        ph_d     = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (sw_done) begin
                            if (i_q == 8'hFF) begin
                                state_d = ST_PRGA;
                                ph_d    = PH_LEN;
                            end else begin
                                ph_d = PH_START;
                            end
                        end
                    end
                    default: ph_d = PH_START;
                endcase
            end
            ST_PRGA: begin
                unique case (ph_q)
                    PH_LEN: ph_d = PH_LENW;
                    PH_LENW: begin
                        ct_wren   = 1'b1;
                        ct_wrdata = pt_rddata;
                        if (pt_rddata == 8'd0) state_d = ST_IDLE;
                        else                   ph_d    = PH_START;
                    end
                    PH_START: begin
                        sw_start = 1'b1;
                        sw_i     = i_q + 8'd1;
                        ph_d     = PH_WAIT;
                    end
                    PH_WAIT: if (sw_done) ph_d = PH_PAD;
                    PH_PAD: begin
                        top_addr = sw_si + sw_sj;
                        pt_addr  = cnt_q;
                        ph_d     = PH_OUT;
                    end
                    PH_OUT: begin
                        ct_addr   = cnt_q;
                        ct_wrdata = pt_rddata ^ rd_data;
                        ct_wren   = 1'b1;
                        if (cnt_q == len_q) state_d = ST_IDLE;
                        else                ph_d    = PH_START;
                    end
                    default: ph_d = PH_LEN;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ARC4_ENCRYPT_PRINTABLE_CHK_EN
    logic ok_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q <= 1'b0;
        end else if (state_q == ST_IDLE && en) begin
            ok_q <= 1'b1;
        end else if (state_q == ST_PRGA && ph_q == PH_OUT) begin
            ok_q <= ok_q & is_printable(pt_rddata);
        end
    end

    assign pt_printable = rdy & ok_q;
`endif

endmodule
